// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the memory-mapped UART.
package uart_pkg;

    // Strobe decode addresses shared with the core's controller.
    localparam logic [31:0] UART_TX_ADDR = 32'h0000_0400;
    localparam logic [31:0] UART_RX_ADDR = 32'h0000_0404;

    // Load value returned when the RX FIFO holds nothing.
    localparam logic [31:0] RX_EMPTY_VAL = 32'hFFFF_FFFF;

    // Common encoding for both the TX and the RX state machines.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; full/empty resolved with one extra pointer bit.
// A push while full is accepted only if a pop frees the slot on the same edge.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer registers; wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents need no reset since empty masks them.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART: byte stores feed a TX FIFO serialised on tx,
// word loads pop bytes received on rx from an RX FIFO.
module uart_peripheral
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        UART_WRITE_EN,
    input  logic        UART_READ_EN,
    input  logic [7:0]  WD,
    output logic [31:0] RD,
    input  logic        rx,
    output logic        tx,
    output logic        tx_busy,
    output logic        rx_overrun
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);

    // TX path state
    uart_state_e tx_state_q, tx_state_d;
    logic [BW-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;

    // RX path state
    logic          rx_meta_q, rx_sync_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [BW-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          overrun_q, overrun_d;
    logic          rx_push, rx_full, rx_empty;
    logic [7:0]    rx_head;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i  (clk),
        .rst_ni (reset),
        .push   (UART_WRITE_EN && !tx_full),
        .pop    (tx_pop),
        .din    (WD),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i  (clk),
        .rst_ni (reset),
        .push   (rx_push),
        .pop    (UART_READ_EN),
        .din    (rx_shift_q),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    assign tx         = tx_q;
    assign tx_busy    = !tx_empty || (tx_state_q != StIdle);
    assign rx_overrun = overrun_q;
    assign RD         = rx_empty ? RX_EMPTY_VAL : {24'h0, rx_head};

    // TX next state: a stop bit that ends with data queued goes straight to the next start.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                    tx_baud_d  = '0;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                if (tx_baud_q == BIT_END) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = StData;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            StData: begin
                if (tx_baud_q == BIT_END) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = StStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: begin
                if (tx_baud_q == BIT_END) begin
                    tx_baud_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_d       = 1'b0;
                        tx_state_d = StStart;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
        endcase
    end

    // RX next state: all samples are taken mid-bit off the synchronised input.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        overrun_d  = overrun_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    rx_baud_d  = '0;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (rx_baud_q == HALF_END) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    // High at mid-start means the falling edge was a glitch.
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            StData: begin
                if (rx_baud_q == BIT_END) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = StStop;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: begin
                if (rx_baud_q == BIT_END) begin
                    rx_baud_d  = '0;
                    rx_state_d = StIdle;
                    // A low stop bit is a framing error: byte discarded silently.
                    if (rx_sync_q) begin
                        if (rx_full && !UART_READ_EN) overrun_d = 1'b1;
                        else                          rx_push   = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
        endcase
    end

    // State registers, synchroniser and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= StIdle;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Scoreboard bench for uart_peripheral: a loopback monitor decodes tx frames and
// a read monitor checks RD on every load strobe against a queue-based model.
module tb_uart_peripheral;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [7:0]  wd = 8'h00;
    logic [31:0] rd;
    logic        rx = 1'b1;
    logic        tx;
    logic        tx_busy;
    logic        rx_overrun;

    always #5 clk = ~clk;

    uart_peripheral #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .UART_WRITE_EN (we),
        .UART_READ_EN  (re),
        .WD            (wd),
        .RD            (rd),
        .rx            (rx),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .rx_overrun    (rx_overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: bytes waiting to be seen on tx, TX FIFO occupancy, RX FIFO contents.
    byte unsigned tx_exp[$];
    int           tx_fifo_cnt = 0;
    int           tx_frames = 0;
    byte unsigned rx_model[$];
    logic         overrun_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_rd(input string name);
        logic [31:0] e;
        e = (rx_model.size() > 0) ? {24'h0, rx_model[0]} : 32'hFFFF_FFFF;
        check(name, rd, e);
    endtask

    // Caller is at a negedge; the push lands on the following posedge.
    task automatic tx_write(input logic [7:0] b);
        we = 1'b1;
        wd = b;
        if (tx_fifo_cnt < DEPTH) begin
            tx_fifo_cnt++;
            tx_exp.push_back(b);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rx_read();
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    // Drive the first nbits bit-periods of a frame, starting at a negedge.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Full frame; returns just before the mid-stop sample edge, so an optional pop lands on it.
    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
        rx_frame(b, stop_bit, 10);
        rx = 1'b1;
        if (stop_bit) begin
            if (rx_model.size() < DEPTH || pop_at_stop) rx_model.push_back(b);
            else overrun_exp = 1'b1;
        end
        if (pop_at_stop) rx_read();
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b0;
        rx = 1'b1;
        we = 1'b0;
        re = 1'b0;
        #1;
        check({name, "_tx"}, tx, 1'b1);
        check({name, "_rd"}, rd, 32'hFFFF_FFFF);
        check({name, "_busy"}, tx_busy, 1'b0);
        check({name, "_ovr"}, rx_overrun, 1'b0);
        tx_exp.delete();
        tx_fifo_cnt = 0;
        rx_model.delete();
        overrun_exp = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_tx_drain(input string name);
        int k;
        k = 0;
        while ((tx_exp.size() != 0 || tx_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k < 2000) n_pass++;
        else $display("FAIL %s: timeout with %0d frames pending, expected 0", name, tx_exp.size());
        repeat (2) @(negedge clk);
    endtask

    // Decode one tx frame from a detected start bit; abandons it if reset hits.
    task automatic tx_decode();
        logic [7:0] b;
        logic       s;
        if (tx_fifo_cnt > 0) tx_fifo_cnt--;
        repeat (CPB / 2) begin
            @(negedge clk);
            if (!reset) return;
        end
        check("tx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) begin
                @(negedge clk);
                if (!reset) return;
            end
            b[i] = tx;
        end
        repeat (CPB) begin
            @(negedge clk);
            if (!reset) return;
        end
        s = tx;
        check("tx_stop_bit", s, 1'b1);
        tx_frames++;
        if (tx_exp.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected_frame: got byte %h, expected no frame", b);
        end else begin
            check("tx_byte", b, tx_exp.pop_front());
        end
    endtask

    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) tx_decode();
        end
    end

    initial begin : rd_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (re === 1'b1) begin
                if (rx_model.size() > 0) e = {24'h0, rx_model.pop_front()};
                else e = 32'hFFFF_FFFF;
                check("rd_on_read", rd, e);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [9:0] frame;
        int         nreads;
        int         guard;

        do_reset("rst0");

        // Single byte: exact per-cycle tx waveform and busy duration.
        frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        we = 1'b1;
        wd = 8'hA5;
        tx_fifo_cnt++;
        tx_exp.push_back(8'hA5);
        @(negedge clk);
        we = 1'b0;
        check("t1_tx_at_push", tx, 1'b1);
        check("t1_busy_at_push", tx_busy, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("t1_tx_wave", tx, frame[(k - 1) / 4]);
        end
        check("t1_busy_last", tx_busy, 1'b1);
        @(negedge clk);
        check("t1_busy_clear", tx_busy, 1'b0);
        repeat (4) @(negedge clk);

        // Burst of six writes: one goes to the shifter, four fill the FIFO, the sixth drops.
        tx_frames = 0;
        for (int b = 1; b <= 6; b++) tx_write(8'(b));
        check("t2_busy", tx_busy, 1'b1);
        wait_tx_drain("t2_drain");
        repeat (50) @(negedge clk);
        check("t2_frame_count", tx_frames, 5);
        check("t2_tx_idle", tx, 1'b1);

        // Randomised TX traffic, paced so the FIFO never fills.
        for (int i = 0; i < 10; i++) begin
            guard = 0;
            while (tx_fifo_cnt >= DEPTH - 1 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            tx_write(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_tx_drain("tr_drain");

        // Single received byte, then pop it.
        check_rd("t3_rd_empty");
        rx_send(8'h3C, 1'b1, 1'b0);
        check_rd("t3_rd_byte");
        rx_read();
        check_rd("t3_rd_after_pop");

        // Glitch and framing error leave nothing behind.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check_rd("t4_glitch");
        rx_send(8'h77, 1'b0, 1'b0);
        check_rd("t4_framing");
        check("t4_no_overrun", rx_overrun, overrun_exp);
        rx_send(8'hE1, 1'b1, 1'b0);
        check_rd("t4_after_glitch");
        rx_read();

        // Five frames without reads: the fifth overruns.
        for (int i = 0; i < 5; i++) rx_send(8'(8'h11 + i), 1'b1, 1'b0);
        check("t5_overrun", rx_overrun, overrun_exp);
        for (int i = 0; i < 5; i++) rx_read();
        check_rd("t5_drained");

        // Pop on the same edge as the fifth stop sample: no overrun.
        do_reset("rst5");
        for (int i = 0; i < 4; i++) rx_send(8'(8'h21 + i), 1'b1, 1'b0);
        rx_send(8'h25, 1'b1, 1'b1);
        check("t5_pop_no_overrun", rx_overrun, overrun_exp);
        check_rd("t5_head");
        for (int i = 0; i < 5; i++) rx_read();

        // Randomised RX traffic with occasional framing errors and reads.
        do_reset("rst_r");
        for (int i = 0; i < 10; i++) begin
            rx_send(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0), 1'b0);
            check_rd("rr_head");
            nreads = int'($urandom_range(0, 2));
            for (int r = 0; r < nreads; r++) rx_read();
        end
        check("rr_overrun", rx_overrun, overrun_exp);
        for (int i = 0; i < 5; i++) rx_read();

        // Reset mid TX data and mid RX frame, then clean traffic.
        do_reset("rst6a");
        tx_write(8'h5A);
        rx_frame(8'hC3, 1'b1, 4);
        do_reset("rst6");
        tx_write(8'h96);
        rx_send(8'h69, 1'b1, 1'b0);
        check_rd("t6_rd");
        rx_read();
        wait_tx_drain("t6_drain");
        check("t6_busy", tx_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
